// File: rtl/ps2_pkg.sv
// Shared constants and state encoding for the PS/2 device-to-host byte receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int unsigned PS2_DATA_BITS      = 8;
  localparam int unsigned PS2_FRAME_BITS     = 11;
  localparam int unsigned PS2_FILTER_LEN_DEF = 8;
  localparam int unsigned PS2_TIMEOUT_DEF    = 100000;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus persistence filter for one raw PS/2 pin.
// The filtered level only follows the synced level once they have differed
// for FILTER_LEN consecutive cycles; shorter excursions restart the count.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic             sync1_q;
  logic             sync2_q;
  logic             filt_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronise the asynchronous pin; idle PS/2 lines float high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles of disagreement and adopt the new level at FILTER_LEN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else if (sync2_q == filt_q) begin
      cnt_q  <= '0;
    end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
      filt_q <= sync2_q;
      cnt_q  <= '0;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/ps2_byte_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd
// parity, stop. Good bytes leave with a one-cycle out_valid strobe; bad or
// stalled frames produce a one-cycle frame_err and the receiver returns idle.
module ps2_byte_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = PS2_FILTER_LEN_DEF,
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] out_byte,
  output logic       out_valid,
  output logic       frame_err,
  output logic       busy
);

  // Bit counter is sized to index any bit of a frame.
  localparam int unsigned CNT_W = $clog2(PS2_FRAME_BITS);
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic clk_f;
  logic data_f;
  logic clk_prev_q;
  logic fall_c;
  logic to_term_c;

  ps2_state_e               state_q,     state_d;
  logic [CNT_W-1:0]         cnt_q,       cnt_d;
  logic [PS2_DATA_BITS-1:0] shreg_q,     shreg_d;
  logic                     par_q,       par_d;
  logic [TO_W-1:0]          to_q,        to_d;
  logic [7:0]               out_byte_q,  out_byte_d;
  logic                     out_valid_q, out_valid_d;
  logic                     frame_err_q, frame_err_d;
  logic                     busy_q,      busy_d;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk   (clk),
    .reset (reset),
    .raw   (ps2_clk),
    .filt  (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk   (clk),
    .reset (reset),
    .raw   (ps2_data),
    .filt  (data_f)
  );

  assign fall_c    = clk_prev_q & ~clk_f;
  assign to_term_c = (to_q == TO_W'(TIMEOUT_CYCLES - 1));

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_prev_q  <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      to_q        <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      clk_prev_q  <= clk_f;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      to_q        <= to_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  // Frame sequencing on filtered clock falls, plus the stall watchdog.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    to_d        = to_q;
    out_byte_d  = out_byte_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;

    // Watchdog clears on every fall and in idle, saturating at terminal count.
    if ((state_q == IDLE) || fall_c) begin
      to_d = '0;
    end else if (!to_term_c) begin
      to_d = to_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (fall_c && !data_f) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (fall_c) begin
          shreg_d = {data_f, shreg_q[PS2_DATA_BITS-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(PS2_DATA_BITS - 1)) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall_c) begin
          par_d   = data_f;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall_c) begin
          if (data_f && (^{shreg_q, par_q})) begin
            out_byte_d  = shreg_q;
            out_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fall in the terminal-count cycle takes priority over the abort.
    if ((state_q != IDLE) && !fall_c && to_term_c) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  assign out_byte  = out_byte_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ps2_byte_rx.sv
// Self-checking bench for ps2_byte_rx: table of directed frames, randomized
// frames against a behavioural model, and hand-written corner sequences.
module tb_ps2_byte_rx;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 300;
  localparam int unsigned HALF = 40;
  localparam longint      CLKP = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       frame_err;
  logic       busy;

  ps2_byte_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] b;
    longint     t;
  } ev_t;

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    bit         exp_v;
    bit         exp_e;
    logic [7:0] exp_byte;
  } vec_t;

  ev_t        ev_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         prev_pulse = 1'b0;
  longint     last_fall_t = 0;
  logic [7:0] model_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Pulse monitor: records every output pulse and checks pulse hygiene.
  always @(negedge clk) begin
    if (reset) begin
      prev_pulse = 1'b0;
    end else begin
      if (out_valid || frame_err) begin
        check("pulse_exclusive", 32'(out_valid & frame_err), 32'd0);
        check("pulse_not_back_to_back", 32'(prev_pulse), 32'd0);
        ev_q.push_back('{is_err: frame_err, b: out_byte, t: $time});
      end
      prev_pulse = out_valid | frame_err;
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One device-driven bit: data set while clock high, host samples on the fall.
  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      tick(HALF / 4);
      ps2_clk = 1'b0;
      tick(FL - 1);
      ps2_clk = 1'b1;
      tick(HALF / 4);
      ps2_data = ~b;
      tick(FL - 1);
      ps2_data = b;
      tick(HALF - 2 * (HALF / 4) - 2 * (FL - 1));
    end else begin
      tick(HALF);
    end
    ps2_clk     = 1'b0;
    last_fall_t = $time;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input bit glitch, input int nbits);
    logic [10:0] fr;
    fr = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i], glitch);
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic expect_frame(input string tag, input bit exp_v, input bit exp_e,
                              input logic [7:0] exp_byte, input longint extra_lat);
    ev_t    e;
    int     n_exp;
    n_exp = int'(exp_v) + int'(exp_e);
    check({tag, "_pulses"}, 32'(ev_q.size()), 32'(n_exp));
    if (ev_q.size() > 0 && n_exp > 0) begin
      e = ev_q.pop_front();
      check({tag, "_is_err"}, 32'(e.is_err), 32'(exp_e));
      if (exp_v) check({tag, "_event_byte"}, 32'(e.b), 32'(exp_byte));
      check_range({tag, "_latency"}, (e.t - last_fall_t) / CLKP,
                  longint'(FL) + 2 + extra_lat, longint'(FL) + 4 + extra_lat);
    end
    check({tag, "_out_byte"}, 32'(out_byte), 32'(exp_byte));
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    ev_q.delete();
  endtask

  initial begin
    vec_t        tbl[6];
    logic [7:0]  d;
    logic        par;
    logic        stop;
    bit          good;

    tbl[0] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[1] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[2] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 8'h5A};
    tbl[3] = '{8'h08, 1'b0, 1'b1, 1'b1, 1'b0, 8'h08};
    tbl[4] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01};
    tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF};

    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(3);
    check("reset_outputs", 32'({out_byte, out_valid, frame_err, busy}), 32'd0);
    reset = 1'b0;
    tick(20);
    check("post_reset_outputs", 32'({out_byte, out_valid, frame_err, busy}), 32'd0);

    // Directed frames: bad parity, bad stop, then good bytes.
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].d, tbl[i].par, tbl[i].stop, 1'b0, 11);
      tick(10);
      expect_frame($sformatf("tbl%0d", i), tbl[i].exp_v, tbl[i].exp_e, tbl[i].exp_byte, 0);
    end
    model_byte = 8'hFF;

    // Fall with data high in idle is not a start bit.
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    tick(HALF);
    check("no_start_pulses", 32'(ev_q.size()), 32'd0);
    check("no_start_busy", 32'(busy), 32'd0);

    // Randomized frames against an odd-parity model.
    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom);
      par  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 3) == 0) par = ~par;
      stop = ($urandom_range(0, 7) != 0);
      good = stop && (($countones(d) + int'(par)) % 2 == 1);
      if (good) model_byte = d;
      send_frame(d, par, stop, 1'b0, 11);
      tick(10);
      expect_frame($sformatf("rand%0d", i), good, !good, model_byte, 0);
    end

    // Sub-threshold glitches on both pins must not disturb the frame.
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 11);
    tick(10);
    model_byte = 8'hA5;
    expect_frame("glitch", 1'b1, 1'b0, model_byte, 0);

    // Stall after start plus four data bits, then a clean frame.
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 5);
    check("stall_busy", 32'(busy), 32'd1);
    tick(TO + 50);
    expect_frame("timeout", 1'b0, 1'b1, model_byte, longint'(TO));
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 11);
    tick(10);
    model_byte = 8'h3C;
    expect_frame("after_timeout", 1'b1, 1'b0, model_byte, 0);

    // Reset mid-frame loses the partial frame silently.
    send_frame(8'h77, 1'b1, 1'b1, 1'b0, 4);
    check("mid_frame_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check($sformatf("mid_reset_outputs%0d", i),
            32'({out_byte, out_valid, frame_err, busy}), 32'd0);
    end
    reset = 1'b0;
    tick(20);
    check("reset_no_pulse", 32'(ev_q.size()), 32'd0);
    send_frame(8'h77, 1'b1, 1'b1, 1'b0, 11);
    tick(10);
    model_byte = 8'h77;
    expect_frame("after_reset", 1'b1, 1'b0, model_byte, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
